// File: rtl/multu_hilo.sv
// Multi-cycle unsigned shift-add multiplier with HI/LO result registers.
// Started by the MULTU funct code; MFHI/MFLO read the product back through dataOut.
module multu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q,  prod_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [WIDTH-1:0]     hi_q,    hi_d;
    logic [WIDTH-1:0]     lo_q,    lo_d;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   step_s;

    // One shift-add step; the W+1-bit sum keeps the carry out of the upper half.
    function automatic logic [2*WIDTH-1:0] shift_add_step(
        input logic [2*WIDTH-1:0] prod,
        input logic [WIDTH-1:0]   mcand
    );
        logic [WIDTH:0] sum;
        if (prod[0]) begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        end
        return {sum, prod[WIDTH-1:1]};
    endfunction

    // Next-state logic for the multiply sequencer and the HI/LO registers.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        step_s  = shift_add_step(prod_q, mcand_q);
        case (state_q)
            IDLE: begin
                if (Signal == FUNCT_MULTU) begin
                    state_d = MUL;
                    mcand_d = dataA;
                    prod_d  = {{WIDTH{1'b0}}, dataB};
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                prod_d = step_s;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    hi_d    = step_s[2*WIDTH-1:WIDTH];
                    lo_d    = step_s[WIDTH-1:0];
                    state_d = DONE;
                end else begin
                    state_d = MUL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == MUL);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // Read-back mux: HI or LO on MFHI/MFLO, zero for every other funct code.
    always_comb begin
        case (Signal)
            FUNCT_MFHI: dataOut = hi_q;
            FUNCT_MFLO: dataOut = lo_q;
            default:    dataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Randomized and directed bench for multu_hilo against a plain-arithmetic product model.
module tb_multu_hilo;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA, dataB;
    logic [5:0]  Signal;
    logic [31:0] dataOut;
    logic        busy, done;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    multu_hilo #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .dataOut(dataOut),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] expected_out(input logic [5:0] f);
        if (f == F_MFHI) return hi_m;
        if (f == F_MFLO) return lo_m;
        return 32'h0;
    endfunction

    // Read HI and LO through the mux and compare with the model.
    task automatic read_hilo(input string tag);
        Signal = F_MFHI;
        #1 check_val({tag, "_hi"}, 64'(dataOut), 64'(hi_m));
        Signal = F_MFLO;
        #1 check_val({tag, "_lo"}, 64'(dataOut), 64'(lo_m));
    endtask

    // Full multiply: start, 32 busy cycles with optional random disturbance, one done cycle.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit noisy);
        logic [63:0] p;
        int          sel;
        p = {32'h0, a} * {32'h0, b};
        @(negedge clk);
        Signal = F_MULTU;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            check_val("busy_mul", 64'(busy), 64'd1);
            check_val("done_mul", 64'(done), 64'd0);
            if (noisy) begin
                dataA = $urandom;
                dataB = $urandom;
                sel = (c == 10) ? 0 : int'($urandom_range(0, 3));
                case (sel)
                    0:       Signal = F_MULTU;
                    1:       Signal = F_MFHI;
                    2:       Signal = F_MFLO;
                    default: Signal = F_ADD;
                endcase
            end else begin
                Signal = (c[0]) ? F_MFHI : F_MFLO;
            end
            #1 check_val("old_out", 64'(dataOut), 64'(expected_out(Signal)));
        end
        @(negedge clk);
        hi_m = p[63:32];
        lo_m = p[31:0];
        check_val("done_pulse", 64'(done), 64'd1);
        check_val("busy_done", 64'(busy), 64'd0);
        read_hilo("result");
        @(negedge clk);
        Signal = F_ADD;
        #1 check_val("idle_out", 64'(dataOut), 64'd0);
        check_val("done_clear", 64'(done), 64'd0);
        check_val("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        reset  = 1'b0;
        Signal = 6'b000000;
        dataA  = 32'h0;
        dataB  = 32'h0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        read_hilo("rst");
        reset = 1'b1;

        do_mult(32'd3, 32'd5, 1'b0);
        check_val("t1_lo_const", 64'(lo_m), 64'h0000_000F);

        // Upper-half carry path with all-ones operands.
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_mult(32'h1234_5678, 32'h0, 1'b0);
        do_mult(32'h0, 32'hDEAD_BEEF, 1'b0);
        do_mult(32'd2, 32'd7, 1'b1);
        do_mult(32'd3, 32'd5, 1'b0);
        do_mult(32'h0001_0000, 32'h0001_0000, 1'b0);

        // Reset in the middle of a multiply clears everything immediately.
        @(negedge clk);
        Signal = F_MULTU;
        dataA  = 32'hCAFE_F00D;
        dataB  = 32'h0BAD_BEEF;
        repeat (16) @(negedge clk);
        Signal = F_ADD;
        check_val("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b0;
        hi_m  = 32'h0;
        lo_m  = 32'h0;
        #1;
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_done", 64'(done), 64'd0);
        read_hilo("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        do_mult(32'd11, 32'd13, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_mult($urandom, $urandom, bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
